uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter (tx_data/new_tx_data/tx_busy) between NUM_REQ byte-stream sources:

---
 rtl/uart_arb_pkg.sv | 12 +
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/rr_priority_picker.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and byte width.
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_HOLD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Source-side byte streams plus the transmitter handshake of the UART TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  import uart_arb_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        grant;
  logic [BYTE_W-1:0]         tx_data;
  logic                      new_tx_data;
  logic                      tx_busy;

  modport master (
    output req, req_data, req_valid, req_last, tx_busy,
    input  req_ready, grant, tx_data, new_tx_data
  );

  modport slave (
    input  req, req_data, req_valid, req_last, tx_busy,
    output req_ready, grant, tx_data, new_tx_data
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request strictly after rr_ptr, wrapping; one-hot result.
module rr_priority_picker #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         pick,
  output logic                       found
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] idx_s;

  // Scan from rr_ptr+1 around the ring, keeping only the first hit
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx_s = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s       = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      pick[idx_s] = req[idx_s] & ~found;
      found       = found | req[idx_s];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ message sources.
// Optional stall release of a silent owner: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus,
  output logic              timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  arb_state_e          state_r, state_s;
  logic [NUM_REQ-1:0]  grant_r, grant_s;
  logic [IDX_W-1:0]    rr_ptr_r, rr_ptr_s;
  logic [IDX_W-1:0]    owner_r, owner_s;
  logic [BYTE_W-1:0]   tx_data_r, tx_data_s;
  logic                new_tx_data_r, new_tx_data_s;
  logic                last_r, last_s;

  logic [NUM_REQ-1:0]  pick_s;
  logic                found_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                sel_req_s, sel_valid_s, sel_last_s;
  logic [BYTE_W-1:0]   sel_data_s;
  logic                accept_s;
  logic                stall_hit_s;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr_r),
    .pick   (pick_s),
    .found  (found_s)
  );

  // One-hot pick to index
  always_comb begin
    pick_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_idx_s = pick_idx_s | ({IDX_W{pick_s[i]}} & IDX_W'(i));
    end
  end

  assign sel_req_s   = bus.req[owner_r];
  assign sel_valid_s = bus.req_valid[owner_r];
  assign sel_last_s  = bus.req_last[owner_r];
  assign sel_data_s  = bus.req_data[int'(owner_r) * BYTE_W +: BYTE_W];
  assign accept_s    = (state_r == ARB_SEND) & sel_valid_s & ~bus.tx_busy;

  // Only the owner sees ready, and only in the accepting cycle
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = accept_s & (owner_r == IDX_W'(i));
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s       = state_r;
    grant_s       = grant_r;
    rr_ptr_s      = rr_ptr_r;
    owner_s       = owner_r;
    tx_data_s     = tx_data_r;
    new_tx_data_s = 1'b0;
    last_s        = last_r;
    case (state_r)
      ARB_IDLE: begin
        if (found_s) begin
          grant_s  = pick_s;
          rr_ptr_s = pick_idx_s;
          owner_s  = pick_idx_s;
          state_s  = ARB_SEND;
        end else begin
          state_s  = ARB_IDLE;
        end
      end
      ARB_SEND: begin
        if (accept_s) begin
          tx_data_s     = sel_data_s;
          new_tx_data_s = 1'b1;
          last_s        = sel_last_s;
          state_s       = ARB_HOLD;
        end else if (!sel_req_s || stall_hit_s) begin
          grant_s = '0;
          state_s = ARB_IDLE;
        end else begin
          state_s = ARB_SEND;
        end
      end
      ARB_HOLD: begin
        // Gives the transmitter one cycle to raise tx_busy before the next byte
        if (last_r) begin
          grant_s = '0;
          state_s = ARB_IDLE;
        end else begin
          state_s = ARB_SEND;
        end
      end
      default: begin
        grant_s = '0;
        state_s = ARB_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ARB_IDLE;
      grant_r       <= '0;
      rr_ptr_r      <= PTR_INIT;
      owner_r       <= '0;
      tx_data_r     <= {BYTE_W{1'b0}};
      new_tx_data_r <= 1'b0;
      last_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      grant_r       <= grant_s;
      rr_ptr_r      <= rr_ptr_s;
      owner_r       <= owner_s;
      tx_data_r     <= tx_data_s;
      new_tx_data_r <= new_tx_data_s;
      last_r        <= last_s;
    end
  end

  assign bus.grant       = grant_r;
  assign bus.tx_data     = tx_data_r;
  assign bus.new_tx_data = new_tx_data_r;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] stall_r, stall_s;
  logic        timeout_r, timeout_s;

  assign stall_hit_s = (state_r == ARB_SEND) & ~sel_valid_s &
                       ((stall_r + 16'd1) == 16'(TIMEOUT_CYCLES));
  assign timeout_s   = stall_hit_s & sel_req_s;

  // Stall count restarts on every grant and every accepted byte
  always_comb begin
    stall_s = stall_r;
    if ((state_r == ARB_IDLE) && found_s) begin
      stall_s = 16'd0;
    end else if (accept_s) begin
      stall_s = 16'd0;
    end else if ((state_r == ARB_SEND) && !sel_valid_s) begin
      stall_s = stall_r + 16'd1;
    end else begin
      stall_s = stall_r;
    end
  end

  // Stall counter and timeout pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r   <= 16'd0;
      timeout_r <= 1'b0;
    end else begin
      stall_r   <= stall_s;
      timeout_r <= timeout_s;
    end
  end

  assign timeout = timeout_r;
`else
  assign stall_hit_s = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a source model and a 3-cycle-busy transmitter model.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NUM_REQ = 3;

  logic clk = 1'b0;
  logic rst;
  logic timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .timeout (timeout)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [NUM_REQ-1:0] req_cmd;
  logic [NUM_REQ-1:0] done_mask;
  logic [NUM_REQ-1:0] pending;
  logic               drop_on_last;
  logic               force_busy;
  int                 busy_cnt;
  int                 busy_viol;
  logic [2:0]         prev_grant;

  logic [8:0]  src_q [NUM_REQ][$];
  logic [10:0] strobe_log [$];
  logic [2:0]  grant_log [$];

  assign bus.req     = req_cmd & ~done_mask;
  assign bus.tx_busy = force_busy | (busy_cnt != 0);

  // Source model: present queue heads at negedge, pop after an accepting posedge
  initial begin
    pending       = '0;
    done_mask     = '0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        done_mask[i] = done_mask[i] & req_cmd[i];
        if (pending[i] && src_q[i].size() > 0) begin
          if (src_q[i][0][8] && drop_on_last) done_mask[i] = 1'b1;
          void'(src_q[i].pop_front());
        end
        if (src_q[i].size() > 0) begin
          bus.req_valid[i]     = 1'b1;
          bus.req_data[8*i +: 8] = src_q[i][0][7:0];
          bus.req_last[i]      = src_q[i][0][8];
        end else begin
          bus.req_valid[i]     = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]      = 1'b0;
        end
      end
      #4;
      pending = bus.req_ready;
    end
  end

  // Transmitter model and strobe/grant logging
  initial begin
    busy_cnt   = 0;
    busy_viol  = 0;
    prev_grant = 3'b000;
    forever begin
      @(negedge clk);
      if (bus.new_tx_data) begin
        strobe_log.push_back({bus.grant, bus.tx_data});
        if (bus.tx_busy) busy_viol++;
        busy_cnt = 3;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      if (bus.grant != 3'b000 && prev_grant == 3'b000) grant_log.push_back(bus.grant);
      prev_grant = bus.grant;
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic idle_sources();
    req_cmd = 3'b000;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    repeat (6) step();
  endtask

  task automatic do_reset();
    idle_sources();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    strobe_log.delete();
    grant_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    vectors++;
    if (bus.grant !== 3'b000) begin miscompares++; $display("FAIL reset_grant: got %b expected 000", bus.grant); end
    vectors++;
    if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    vectors++;
    if (bus.new_tx_data !== 1'b0) begin miscompares++; $display("FAIL reset_strobe: got %b expected 0", bus.new_tx_data); end
    vectors++;
    if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    vectors++;
    if (bus.req_ready !== 3'b000) begin miscompares++; $display("FAIL reset_ready: got %b expected 000", bus.req_ready); end
    rst = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_single_source();
    int n;
    do_reset();
    drop_on_last = 1'b1;
    src_q[1].push_back({1'b0, 8'h4F});
    src_q[1].push_back({1'b1, 8'h4B});
    req_cmd = 3'b010;
    step();
    vectors++;
    if (bus.grant !== 3'b010) begin miscompares++; $display("FAIL t1_grant_latency: got %b expected 010", bus.grant); end
    n = 0;
    while (!(strobe_log.size() >= 2 && bus.grant == 3'b000) && n < 60) begin step(); n++; end
    vectors++;
    if (n >= 60) begin miscompares++; $display("FAIL t1_wait: got timeout expected 2 strobes then release"); end
    repeat (10) step();
    vectors++;
    if (strobe_log.size() !== 2) begin miscompares++; $display("FAIL t1_strobe_count: got %0d expected 2", strobe_log.size()); end
    if (strobe_log.size() >= 2) begin
      vectors++;
      if (strobe_log[0] !== {3'b010, 8'h4F}) begin miscompares++; $display("FAIL t1_byte0: got %h expected %h", strobe_log[0], {3'b010, 8'h4F}); end
      vectors++;
      if (strobe_log[1] !== {3'b010, 8'h4B}) begin miscompares++; $display("FAIL t1_byte1: got %h expected %h", strobe_log[1], {3'b010, 8'h4B}); end
    end
    vectors++;
    if (bus.grant !== 3'b000) begin miscompares++; $display("FAIL t1_release: got %b expected 000", bus.grant); end
    idle_sources();
  endtask

  task automatic test_round_robin();
    int n;
    logic [2:0] exp_g [4];
    logic [7:0] exp_d [3];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    exp_d[0] = 8'h30;  exp_d[1] = 8'h31;  exp_d[2] = 8'h32;
    do_reset();
    drop_on_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].push_back({1'b1, exp_d[i]});
    req_cmd = 3'b111;
    n = 0;
    while (grant_log.size() < 4 && n < 200) begin step(); n++; end
    vectors++;
    if (grant_log.size() < 4) begin miscompares++; $display("FAIL t2_grants: got %0d grants expected 4", grant_log.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) begin
        vectors++;
        if (grant_log[i] !== exp_g[i]) begin miscompares++; $display("FAIL t2_grant_order[%0d]: got %b expected %b", i, grant_log[i], exp_g[i]); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= strobe_log.size()) begin miscompares++; $display("FAIL t2_byte[%0d]: got none expected %h", i, exp_d[i]); end
      else if (strobe_log[i][7:0] !== exp_d[i]) begin miscompares++; $display("FAIL t2_byte[%0d]: got %h expected %h", i, strobe_log[i][7:0], exp_d[i]); end
    end
    idle_sources();
    vectors++;
    if (bus.grant !== 3'b000) begin miscompares++; $display("FAIL t2_abort: got %b expected 000", bus.grant); end
    drop_on_last = 1'b1;
  endtask

  task automatic test_no_interleave();
    int n;
    logic [10:0] exp_s [4];
    exp_s[0] = {3'b001, 8'hA0}; exp_s[1] = {3'b001, 8'hA1};
    exp_s[2] = {3'b001, 8'hA2}; exp_s[3] = {3'b100, 8'hC0};
    do_reset();
    drop_on_last = 1'b1;
    src_q[0].push_back({1'b0, 8'hA0});
    src_q[0].push_back({1'b0, 8'hA1});
    src_q[0].push_back({1'b1, 8'hA2});
    src_q[2].push_back({1'b1, 8'hC0});
    req_cmd = 3'b001;
    step();
    req_cmd = 3'b101;
    n = 0;
    while (strobe_log.size() < 4 && n < 200) begin step(); n++; end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= strobe_log.size()) begin miscompares++; $display("FAIL t3_seq[%0d]: got none expected %h", i, exp_s[i]); end
      else if (strobe_log[i] !== exp_s[i]) begin miscompares++; $display("FAIL t3_seq[%0d]: got %h expected %h", i, strobe_log[i], exp_s[i]); end
    end
    vectors++;
    if (grant_log.size() < 2 || grant_log[1] !== 3'b100) begin miscompares++; $display("FAIL t3_next_grant: got %0d grants expected 2nd grant 100", grant_log.size()); end
    idle_sources();
  endtask

  task automatic test_busy_stall();
    int bad;
    do_reset();
    drop_on_last = 1'b1;
    force_busy = 1'b1;
    src_q[1].push_back({1'b1, 8'h55});
    req_cmd = 3'b010;
    bad = 0;
    repeat (50) begin
      step();
      if (bus.req_ready !== 3'b000 || bus.new_tx_data !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0 || strobe_log.size() != 0) begin miscompares++; $display("FAIL t4_stalled: got %0d bad cycles, %0d strobes expected 0", bad, strobe_log.size()); end
    force_busy = 1'b0;
    step();
    vectors++;
    if (bus.new_tx_data !== 1'b1) begin miscompares++; $display("FAIL t4_strobe: got %b expected 1", bus.new_tx_data); end
    vectors++;
    if (bus.tx_data !== 8'h55) begin miscompares++; $display("FAIL t4_data: got %h expected 55", bus.tx_data); end
    repeat (10) step();
    vectors++;
    if (strobe_log.size() !== 1) begin miscompares++; $display("FAIL t4_count: got %0d expected 1", strobe_log.size()); end
    idle_sources();
  endtask

  task automatic test_reset_in_hold();
    int n;
    do_reset();
    drop_on_last = 1'b1;
    src_q[0].push_back({1'b0, 8'h10});
    src_q[0].push_back({1'b1, 8'h11});
    req_cmd = 3'b001;
    n = 0;
    while (bus.new_tx_data !== 1'b1 && n < 30) begin step(); n++; end
    vectors++;
    if (n >= 30) begin miscompares++; $display("FAIL t5_hold: got no strobe expected one"); end
    rst = 1'b1;
    step();
    vectors++;
    if (bus.grant !== 3'b000) begin miscompares++; $display("FAIL t5_grant: got %b expected 000", bus.grant); end
    vectors++;
    if (bus.new_tx_data !== 1'b0) begin miscompares++; $display("FAIL t5_strobe: got %b expected 0", bus.new_tx_data); end
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    rst = 1'b0;
    req_cmd = 3'b110;
    step();
    vectors++;
    if (bus.grant !== 3'b010) begin miscompares++; $display("FAIL t5_regrant: got %b expected 010", bus.grant); end
    idle_sources();
  endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    drop_on_last = 1'b1;
    src_q[1].push_back({1'b1, 8'h77});
    req_cmd = 3'b011;
    step();
    vectors++;
    if (bus.grant !== 3'b001) begin miscompares++; $display("FAIL t6_first_grant: got %b expected 001", bus.grant); end
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin step(); n++; end
    vectors++;
    if (n != 8) begin miscompares++; $display("FAIL t6_delay: got %0d cycles expected 8", n); end
    vectors++;
    if (bus.grant !== 3'b000) begin miscompares++; $display("FAIL t6_release: got %b expected 000", bus.grant); end
    step();
    vectors++;
    if (timeout !== 1'b0) begin miscompares++; $display("FAIL t6_pulse: got %b expected 0", timeout); end
    vectors++;
    if (bus.grant !== 3'b010) begin miscompares++; $display("FAIL t6_next_grant: got %b expected 010", bus.grant); end
    idle_sources();
  endtask
`endif

  task automatic test_invariants();
    vectors++;
    if (busy_viol != 0) begin miscompares++; $display("FAIL strobe_while_busy: got %0d expected 0", busy_viol); end
  endtask

  initial begin
    rst          = 1'b1;
    req_cmd      = 3'b000;
    drop_on_last = 1'b1;
    force_busy   = 1'b0;
    test_reset();
    test_single_source();
    test_round_robin();
    test_no_interleave();
    test_busy_stall();
    test_reset_in_hold();
`ifdef UART_TX_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
